// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath: the opcode and
// memory handshake come in, the datapath enables/selects and debug state go out.
interface multicycle_control_if;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic [3:0] state;

    // Datapath / stimulus side
    modport master (
        output opCode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, state
    );

    // Controller side
    modport slave (
        input  opCode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (Moore). Outputs are registered alongside the
// state: each edge loads the control word belonging to the state being
// entered, so outputs and state always change together.
// Optional feature: define MC_ADDI_EN to add the ADDIEXEC/ADDIWB path for
// opcode 001000; without it that opcode is treated as illegal.
// irWrite and the fetch-time pcWrite are the only memReady-qualified outputs:
// a registered "fetch" bit is ANDed with memReady so the instruction register
// and PC are written only on the cycle memory completes.
module multicycle_control (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.slave   bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
`ifdef MC_ADDI_EN
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
`endif
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       fetch;
    } ctl_t;

    state_t cur_state;
    ctl_t   ctl_q;
    logic   illegal_q;

    // Next-state function of the FSM.
    function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                       input logic rdy);
        next_of = FETCH;
        case (s)
            FETCH:    next_of = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    6'b100011, 6'b101011: next_of = MEMADR;
                    6'b000000:            next_of = EXECUTE;
                    6'b000100:            next_of = BRANCH;
                    6'b000010:            next_of = JUMP;
`ifdef MC_ADDI_EN
                    6'b001000:            next_of = ADDIEXEC;
`endif
                    default:              next_of = FETCH;
                endcase
            end
            MEMADR:   next_of = (op == 6'b100011) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_of = rdy ? MEMWB : MEMREAD;
            MEMWB:    next_of = FETCH;
            MEMWRITE: next_of = rdy ? FETCH : MEMWRITE;
            EXECUTE:  next_of = ALUWB;
            ALUWB:    next_of = FETCH;
            BRANCH:   next_of = FETCH;
            JUMP:     next_of = FETCH;
`ifdef MC_ADDI_EN
            ADDIEXEC: next_of = ADDIWB;
            ADDIWB:   next_of = FETCH;
`endif
            default:  next_of = FETCH;
        endcase
    endfunction

    // Control word presented while in state s; anything not listed stays 0.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_of = '0;
        case (s)
            FETCH: begin
                ctl_of.mem_read  = 1'b1;
                ctl_of.alu_src_b = 2'b01;
                ctl_of.fetch     = 1'b1;
            end
            DECODE:   ctl_of.alu_src_b = 2'b11;
            MEMADR: begin
                ctl_of.alu_src_a = 1'b1;
                ctl_of.alu_src_b = 2'b10;
            end
            MEMREAD: begin
                ctl_of.mem_read = 1'b1;
                ctl_of.ior_d    = 1'b1;
            end
            MEMWB: begin
                ctl_of.reg_write  = 1'b1;
                ctl_of.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                ctl_of.mem_write = 1'b1;
                ctl_of.ior_d     = 1'b1;
            end
            EXECUTE: begin
                ctl_of.alu_src_a = 1'b1;
                ctl_of.alu_op    = 2'b10;
            end
            ALUWB: begin
                ctl_of.reg_write = 1'b1;
                ctl_of.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctl_of.alu_src_a     = 1'b1;
                ctl_of.alu_op        = 2'b01;
                ctl_of.pc_write_cond = 1'b1;
                ctl_of.pc_source     = 2'b01;
            end
            JUMP: begin
                ctl_of.pc_write  = 1'b1;
                ctl_of.pc_source = 2'b10;
            end
`ifdef MC_ADDI_EN
            ADDIEXEC: begin
                ctl_of.alu_src_a = 1'b1;
                ctl_of.alu_src_b = 2'b10;
            end
            ADDIWB:   ctl_of.reg_write = 1'b1;
`endif
            default:  ctl_of = '0;
        endcase
    endfunction

    // True for opcodes DECODE cannot dispatch.
    function automatic logic is_illegal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: is_illegal = 1'b0;
`ifdef MC_ADDI_EN
            6'b001000: is_illegal = 1'b0;
`endif
            default:   is_illegal = 1'b1;
        endcase
    endfunction

    // Unused encodings leave like FETCH but with a quiet (all-zero) control word.
    function automatic logic is_known(input state_t s);
        case (s)
            FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
            EXECUTE, ALUWB, BRANCH, JUMP: is_known = 1'b1;
`ifdef MC_ADDI_EN
            ADDIEXEC, ADDIWB: is_known = 1'b1;
`endif
            default: is_known = 1'b0;
        endcase
    endfunction

    // State, registered control word and illegal-opcode pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            ctl_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_of(cur_state, bus.opCode, bus.memReady);
            ctl_q     <= is_known(cur_state) ?
                         ctl_of(next_of(cur_state, bus.opCode, bus.memReady)) : '0;
            illegal_q <= (cur_state == DECODE) && is_illegal(bus.opCode);
        end
    end

    assign bus.pcWrite     = ctl_q.pc_write | (ctl_q.fetch & bus.memReady);
    assign bus.irWrite     = ctl_q.fetch & bus.memReady;
    assign bus.pcWriteCond = ctl_q.pc_write_cond;
    assign bus.iorD        = ctl_q.ior_d;
    assign bus.memRead     = ctl_q.mem_read;
    assign bus.memWrite    = ctl_q.mem_write;
    assign bus.memToReg    = ctl_q.mem_to_reg;
    assign bus.regDst      = ctl_q.reg_dst;
    assign bus.regWrite    = ctl_q.reg_write;
    assign bus.aluSrcA     = ctl_q.alu_src_a;
    assign bus.aluSrcB     = ctl_q.alu_src_b;
    assign bus.aluOp       = ctl_q.alu_op;
    assign bus.pcSource    = ctl_q.pc_source;
    assign bus.illegalOp   = illegal_q;
    assign bus.state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. A driver applies one vector per
// cycle and queues the hand-computed state/output word expected during that
// cycle; a monitor pops and compares on the falling edge.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Output word: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg
    // regDst regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0] illegalOp
    localparam logic [16:0] O_ZERO = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_FWT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FRD  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_EXE  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] O_AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] O_AIE  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_AIW  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] O_FRDI = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_1;
    localparam logic [16:0] O_FWTI = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_1;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic        chk;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    typedef struct {
        int          idx;
        logic        chk;
        logic [3:0]  st;
        logic [16:0] out;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   applied = 0;
    int   miscompares = 0;
    logic [16:0] got_out;
    logic [3:0]  got_st;
    exp_t        cur;

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic chk, input logic [3:0] st, input logic [16:0] out);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.chk = chk; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    assign got_out = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead,
                      bus.memWrite, bus.irWrite, bus.memToReg, bus.regDst,
                      bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.aluOp,
                      bus.pcSource, bus.illegalOp};
    assign got_st  = bus.state;

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                if (cur.chk) begin
                    applied++;
                    if (got_st !== cur.st || got_out !== cur.out) begin
                        miscompares++;
                        $display("FAIL vec%0d: got state=%0d out=%b, expected state=%0d out=%b",
                                 cur.idx, got_st, got_out, cur.st, cur.out);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: build the vector table, then apply one vector per cycle.
    initial begin
        exp_t e;
        bus.opCode   = 6'b0;
        bus.memReady = 1'b0;

        // Reset, then a quiet FETCH and a normal FETCH that holds on memReady=0
        add(1, 6'b000000, 0, 0, 4'd0, O_ZERO);
        add(1, 6'b000000, 0, 0, 4'd0, O_ZERO);
        add(0, 6'b000000, 0, 1, 4'd0, O_ZERO);
        add(0, 6'b000000, 0, 1, 4'd0, O_FWT);
        // lw, zero wait: 0,1,2,3,4
        add(0, 6'b100011, 1, 1, 4'd0, O_FRD);
        add(0, 6'b100011, 1, 1, 4'd1, O_DEC);
        add(0, 6'b100011, 1, 1, 4'd2, O_MADR);
        add(0, 6'b100011, 1, 1, 4'd3, O_MRD);
        add(0, 6'b100011, 1, 1, 4'd4, O_MWB);
        // sw with three wait cycles in MEMWRITE
        add(0, 6'b101011, 1, 1, 4'd0, O_FRD);
        add(0, 6'b101011, 1, 1, 4'd1, O_DEC);
        add(0, 6'b101011, 1, 1, 4'd2, O_MADR);
        add(0, 6'b101011, 0, 1, 4'd5, O_MWR);
        add(0, 6'b101011, 0, 1, 4'd5, O_MWR);
        add(0, 6'b101011, 0, 1, 4'd5, O_MWR);
        add(0, 6'b101011, 1, 1, 4'd5, O_MWR);
        // R-type
        add(0, 6'b000000, 1, 1, 4'd0, O_FRD);
        add(0, 6'b000000, 1, 1, 4'd1, O_DEC);
        add(0, 6'b000000, 1, 1, 4'd6, O_EXE);
        add(0, 6'b000000, 1, 1, 4'd7, O_AWB);
        // beq
        add(0, 6'b000100, 1, 1, 4'd0, O_FRD);
        add(0, 6'b000100, 1, 1, 4'd1, O_DEC);
        add(0, 6'b000100, 1, 1, 4'd8, O_BR);
        // j
        add(0, 6'b000010, 1, 1, 4'd0, O_FRD);
        add(0, 6'b000010, 1, 1, 4'd1, O_DEC);
        add(0, 6'b000010, 1, 1, 4'd11, O_JMP);
        // illegal opcode: one-cycle pulse, back in FETCH
        add(0, 6'b111111, 1, 1, 4'd0, O_FRD);
        add(0, 6'b111111, 1, 1, 4'd1, O_DEC);
        add(0, 6'b100011, 1, 1, 4'd0, O_FRDI);
        add(0, 6'b100011, 1, 1, 4'd1, O_DEC);
        // lw, stalled in MEMREAD, then reset
        add(0, 6'b100011, 1, 1, 4'd2, O_MADR);
        add(0, 6'b100011, 0, 1, 4'd3, O_MRD);
        add(1, 6'b100011, 0, 1, 4'd3, O_MRD);
        add(0, 6'b100011, 0, 1, 4'd0, O_ZERO);
        // addi
        add(0, 6'b001000, 1, 1, 4'd0, O_FRD);
        add(0, 6'b001000, 1, 1, 4'd1, O_DEC);
`ifdef MC_ADDI_EN
        add(0, 6'b001000, 0, 1, 4'd9, O_AIE);
        add(0, 6'b001000, 0, 1, 4'd10, O_AIW);
        add(0, 6'b001000, 0, 1, 4'd0, O_FWT);
`else
        add(0, 6'b001000, 0, 1, 4'd0, O_FWTI);
        add(0, 6'b001000, 0, 1, 4'd0, O_FWT);
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset        = vecs[i].rst;
            bus.opCode   = vecs[i].op;
            bus.memReady = vecs[i].rdy;
            e.idx = i; e.chk = vecs[i].chk; e.st = vecs[i].st; e.out = vecs[i].out;
            sb.push_back(e);
        end

        // Bounded drain of the scoreboard
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
